seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the BCD-to-7-segment encoder. It monitors a multiplexed, active-low 4-digit 7-segment display bus (segments plus digit selects) and debounces each digit strobe. It decodes every glyph back to a 4-bit code and publishes a complete 4-digit frame with a valid pulse. It sits on the frequency-tester board's display-check path, so the bench and the self-test logic can read back exactly what the display is showing.

## Interface
- STABLE, 4: consecutive sampled cycles an (digit select, one-cold) + seg pattern must be unchanged before a digit is accepted; legal range 2..255.
- TIMEOUT, 100000: cycles without a published frame before `stale` asserts; legal range 1..2^24-1.
- clk  in  1  single system clock, all logic rising-edge.
- rst_n  in  1  synchronous reset, active-low.
- seg  in  8  segment bus, active-low, bit7..bit0 = a,b,c,d,e,f,g,DP.
- an  in  4  digit selects, active-low; an[3] = most significant digit.
- digits  out  16  published codes; digits[4i+3:4i] belongs to an[i].
- dp  out  4  published decimal points, 1 = DP lit; dp[i] belongs to an[i].
- frame_valid  out  1  one-cycle pulse when digits/dp update.
- err  out  1  last published frame contained an unrecognised glyph.
- stale  out  1  no frame published for TIMEOUT cycles.

## Operation
- Inputs pass a 2-flop synchroniser (s_an, s_seg); all logic below uses the synchronised values only.
- Glyph decode of s_seg[7:1] (DP ignored, 0 = lit):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5.
  - 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111110→A (dash), 1111111→B (blank).
  - Anything else→F (invalid).
- DP decode: dp bit = ~s_seg[0].
- Strobe FSM, states IDLE, SETTLE, HELD:
  - IDLE: s_an not one-cold (all ones, or more than one zero). Go to SETTLE when s_an becomes one-cold; stability count = 1.
  - SETTLE: count increments each cycle that {s_an,s_seg} equals the previous cycle's value. Any change restarts the count at 1 (stay in SETTLE if still one-cold, else IDLE). When count reaches STABLE, capture into shadow slot i (i = index of the zero bit), set slot flag i, go to HELD.
  - HELD: no further capture. Go to SETTLE (count = 1) when s_an changes to another one-cold value, or IDLE when s_an is not one-cold. Segment changes while s_an is constant are ignored.
- Re-capture of an already-flagged slot before the frame completes overwrites that shadow slot.
- Publish: in the cycle after the capture that makes all four slot flags 1:
  - digits/dp load from shadow.
  - frame_valid = 1.
  - err = 1 if any published code is F, else 0.
  - Slot flags clear.
- The stale counter clears on publish and increments otherwise, saturating at TIMEOUT. stale = (counter == TIMEOUT); it drops in the publish cycle.

## Timing
- Reset (rst_n low at a clock edge) clears:
  - outputs: digits = 0, dp = 0, frame_valid = 0, err = 0, stale = 0;
  - internal state: FSM = IDLE, slot flags, shadow, stability count, stale counter, synchroniser flops (all set to 1 = inactive).
- Reset mid-frame discards all partial captures. The first frame after reset requires four fresh captures.
- Capture latency: a stable pin-level pattern first appearing at edge n is captured at edge n+2+STABLE-1 (2 synchroniser cycles, then STABLE equal samples).
- Publish latency: frame_valid high exactly 1 cycle after the fourth slot's capture. Outputs change only in that cycle and are stable between pulses.
- Minimum digit dwell for capture: STABLE cycles. Shorter strobes or glitches never capture.
- A capture and a publish in the same cycle cannot occur; a capture in the publish cycle lands in the freshly cleared flags.
- stale rises at the clock edge where the counter reaches TIMEOUT and is held until the next publish.

## Test plan
- Scan "1234", no DP, 20-cycle dwell per digit, an 0111→1011→1101→1110, STABLE = 4 → frame_valid one pulse; digits = 16'h1234, dp = 0, err = 0.
- Frame of dash, blank, 0, 8 with DP on digit 1 → digits = 16'hAB08, dp = 4'b0010, err = 0.
- Strobe on an[0] held 3 cycles with STABLE = 4, inside an otherwise valid scan → no capture for slot 0, no frame_valid until a later ≥4-cycle an[0] strobe.
- seg = 8'b01010101 on an[2] → published digits[11:8] = F, err = 1. Next clean frame → err = 0.
- Stop strobing (an = 1111) with TIMEOUT = 50 → stale = 1 exactly 50 cycles after the last publish. Resume a valid scan → stale = 0 with frame_valid.
- Assert rst_n low after 2 of 4 captures → all outputs 0. After release, frame_valid only after 4 new captures.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed, active-low 4-digit 7-segment bus.
// Debounces each digit strobe, decodes its glyph and publishes whole frames.
module seg_scan_decoder #(
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  seg_i,
  input  logic [3:0]  an_i,
  output logic [15:0] digits_o,
  output logic [3:0]  dp_o,
  output logic        frame_valid_o,
  output logic        err_o,
  output logic        stale_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_e;

  logic [3:0]  an_s1_q, an_q, prev_an_q;
  logic [7:0]  seg_s1_q, seg_q, prev_seg_q;
  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  flags_q, flags_d;
  logic [15:0] shadow_q;
  logic [3:0]  shadow_dp_q;
  logic [15:0] digits_q;
  logic [3:0]  dp_q;
  logic        frame_valid_q, err_q;
  logic [23:0] stale_cnt_q, stale_cnt_d;

  logic       an_onecold, same, capture, publish, shadow_err;
  logic [3:0] glyph_code;

  always_comb begin
    glyph_code = 4'hF;
    case (seg_q[7:1])
      7'b0000001: glyph_code = 4'h0;
      7'b1001111: glyph_code = 4'h1;
      7'b0010010: glyph_code = 4'h2;
      7'b0000110: glyph_code = 4'h3;
      7'b1001100: glyph_code = 4'h4;
      7'b0100100: glyph_code = 4'h5;
      7'b0100000: glyph_code = 4'h6;
      7'b0001111: glyph_code = 4'h7;
      7'b0000000: glyph_code = 4'h8;
      7'b0000100: glyph_code = 4'h9;
      7'b1111110: glyph_code = 4'hA;
      7'b1111111: glyph_code = 4'hB;
      default:    glyph_code = 4'hF;
    endcase
  end

  // SETTLE is only ever entered with a one-cold select, so a capture there
  // always targets exactly one slot: the zero bit of an_q, i.e. ~an_q.
  always_comb begin
    an_onecold = 1'b0;
    case (an_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: an_onecold = 1'b1;
      default:                            an_onecold = 1'b0;
    endcase
    same        = ({an_q, seg_q} == {prev_an_q, prev_seg_q});
    capture     = (state_q == SETTLE) && same && (cnt_q == 8'(STABLE - 1));
    publish     = &flags_q;
    flags_d     = (publish ? 4'b0000 : flags_q) | (capture ? ~an_q : 4'b0000);
    shadow_err  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (shadow_q[4*i +: 4] == 4'hF) shadow_err = 1'b1;
    end
    stale_cnt_d = publish ? 24'd0 :
                  (stale_cnt_q == 24'(TIMEOUT)) ? stale_cnt_q : stale_cnt_q + 24'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (an_onecold) begin
            state_q <= SETTLE;
            cnt_q   <= 8'd1;
          end
        end
        SETTLE: begin
          if (capture) begin
            state_q <= HELD;
          end else if (same) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q   <= 8'd1;
            state_q <= an_onecold ? SETTLE : IDLE;
          end
        end
        HELD: begin
          if (an_q != prev_an_q) begin
            cnt_q   <= 8'd1;
            state_q <= an_onecold ? SETTLE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Publishing reads the shadow before this cycle's capture lands in it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      an_s1_q       <= 4'hF;
      an_q          <= 4'hF;
      prev_an_q     <= 4'hF;
      seg_s1_q      <= 8'hFF;
      seg_q         <= 8'hFF;
      prev_seg_q    <= 8'hFF;
      flags_q       <= 4'b0000;
      shadow_q      <= 16'h0000;
      shadow_dp_q   <= 4'b0000;
      digits_q      <= 16'h0000;
      dp_q          <= 4'b0000;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      stale_cnt_q   <= 24'd0;
    end else begin
      an_s1_q       <= an_i;
      an_q          <= an_s1_q;
      prev_an_q     <= an_q;
      seg_s1_q      <= seg_i;
      seg_q         <= seg_s1_q;
      prev_seg_q    <= seg_q;
      flags_q       <= flags_d;
      frame_valid_q <= publish;
      stale_cnt_q   <= stale_cnt_d;
      if (publish) begin
        digits_q <= shadow_q;
        dp_q     <= shadow_dp_q;
        err_q    <= shadow_err;
      end
      for (int i = 0; i < 4; i++) begin
        if (capture && !an_q[i]) begin
          shadow_q[4*i +: 4] <= glyph_code;
          shadow_dp_q[i]     <= ~seg_q[0];
        end
      end
    end
  end

  assign digits_o      = digits_q;
  assign dp_o          = dp_q;
  assign frame_valid_o = frame_valid_q;
  assign err_o         = err_q;
  assign stale_o       = (stale_cnt_q == 24'(TIMEOUT));

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed display scans plus random strobing,
// all checked against a run-length reference model of the display bus.
module tb_seg_scan_decoder;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 50;
  localparam logic [6:0] GLYPH [12] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111110, 7'b1111111};

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  seg_i;
  logic [3:0]  an_i;
  logic [15:0] digits_o;
  logic [3:0]  dp_o;
  logic        frame_valid_o, err_o, stale_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  seg_scan_decoder #(.STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .seg_i(seg_i), .an_i(an_i),
    .digits_o(digits_o), .dp_o(dp_o), .frame_valid_o(frame_valid_o),
    .err_o(err_o), .stale_o(stale_o));

  // Reference model state: the synchronised sample stream, the length of the
  // current run of identical samples, and whether this strobe already captured.
  logic [11:0] m_s1, m_s2, m_prev;
  int          m_run;
  bit          m_done;
  logic [3:0]  m_code [4];
  logic [3:0]  m_dpsh, m_flags;
  int          m_cnt;
  logic [15:0] e_digits = '0;
  logic [3:0]  e_dp = '0;
  logic        e_fv = 1'b0, e_err = 1'b0, e_stale = 1'b0;

  function automatic logic [3:0] ref_decode(input logic [6:0] g);
    for (int c = 0; c < 12; c++) if (GLYPH[c] == g) return 4'(c);
    return 4'hF;
  endfunction

  function automatic logic [31:0] enc(input logic [15:0] codes, input logic [3:0] dps);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {GLYPH[codes[4*i +: 4]], ~dps[i]};
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        m_s1 = '1; m_s2 = '1; m_prev = '1; m_run = 1; m_done = 0;
        for (int i = 0; i < 4; i++) m_code[i] = 4'h0;
        m_dpsh = '0; m_flags = '0; m_cnt = 0;
        e_digits = '0; e_dp = '0; e_fv = 0; e_err = 0; e_stale = 0;
      end else begin
        logic [11:0] samp;
        bit cap;
        samp = m_s2; m_s2 = m_s1; m_s1 = {an_i, seg_i};
        m_run = (samp == m_prev) ? m_run + 1 : 1;
        if (samp[11:8] != m_prev[11:8]) m_done = 0;
        m_prev = samp;
        cap = ($countones(samp[11:8]) == 3) && !m_done && (m_run == STABLE);
        if (m_flags == 4'hF) begin
          e_digits = {m_code[3], m_code[2], m_code[1], m_code[0]};
          e_dp = m_dpsh;
          e_err = 0;
          for (int i = 0; i < 4; i++) if (m_code[i] == 4'hF) e_err = 1;
          e_fv = 1; m_flags = '0; m_cnt = 0;
        end else begin
          e_fv = 0;
          if (m_cnt < TIMEOUT) m_cnt++;
        end
        e_stale = (m_cnt == TIMEOUT);
        if (cap) begin
          m_done = 1;
          for (int i = 0; i < 4; i++) begin
            if (!samp[8+i]) begin
              m_code[i] = ref_decode(samp[7:1]);
              m_dpsh[i] = ~samp[0];
              m_flags[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Observer: tallies cycle-level disagreement with the model and records
  // what each frame_valid pulse published.
  int cyc_bad = 0, dut_fv = 0, ref_fv = 0, since_pub = 0, rise_gap = -1;
  logic [15:0] pub_digits = '0;
  logic [3:0]  pub_dp = '0;
  logic        pub_err = 1'b0, pub_stale = 1'b0, prev_stale = 1'b0;

  initial begin
    forever begin
      @(negedge clk_i);
      if ({digits_o, dp_o, frame_valid_o, err_o, stale_o} !==
          {e_digits, e_dp, e_fv, e_err, e_stale}) cyc_bad++;
      if (e_fv) ref_fv++;
      if (frame_valid_o === 1'b1) begin
        dut_fv++;
        pub_digits = digits_o; pub_dp = dp_o; pub_err = err_o; pub_stale = stale_o;
        since_pub = 0;
      end else begin
        since_pub++;
      end
      if (stale_o === 1'b1 && prev_stale !== 1'b1) rise_gap = since_pub;
      prev_stale = stale_o;
    end
  end

  task automatic step(input logic [3:0] a, input logic [7:0] s);
    @(negedge clk_i);
    an_i = a;
    seg_i = s;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'hF, 8'hFF);
  endtask

  task automatic strobe(input int d, input logic [7:0] s, input int n);
    repeat (n) step(4'b1111 ^ (4'b0001 << d), s);
  endtask

  task automatic scan(input logic [31:0] segs, input int dwell);
    for (int d = 3; d >= 0; d--) strobe(d, segs[8*d +: 8], dwell);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; an_i = 4'hF; seg_i = 8'hFF;
    repeat (3) @(negedge clk_i);
    checks++; if (digits_o !== 16'h0) begin failures++; $display("[TB] FAIL reset_digits: got %h expected 0000", digits_o); end
    checks++; if (dp_o !== 4'h0) begin failures++; $display("[TB] FAIL reset_dp: got %b expected 0000", dp_o); end
    checks++; if (frame_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_fv: got %b expected 0", frame_valid_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (stale_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_stale: got %b expected 0", stale_o); end
    rst_ni = 1'b1;
    idle(4);
  endtask

  task automatic test_basic_scan();
    int base = dut_fv;
    scan(enc(16'h1234, 4'h0), 20);
    idle(10);
    checks++; if (dut_fv - base !== 1) begin failures++; $display("[TB] FAIL basic_pulses: got %0d expected 1", dut_fv - base); end
    checks++; if (pub_digits !== 16'h1234) begin failures++; $display("[TB] FAIL basic_digits: got %h expected 1234", pub_digits); end
    checks++; if (pub_dp !== 4'h0 || pub_err !== 1'b0) begin failures++; $display("[TB] FAIL basic_dp_err: got dp=%b err=%b expected dp=0000 err=0", pub_dp, pub_err); end
    checks++; if (digits_o !== 16'h1234) begin failures++; $display("[TB] FAIL basic_hold: got %h expected 1234", digits_o); end
  endtask

  task automatic test_dash_blank();
    int base = dut_fv;
    scan(enc(16'hAB08, 4'b0010), 20);
    idle(10);
    checks++; if (dut_fv - base !== 1) begin failures++; $display("[TB] FAIL dash_pulses: got %0d expected 1", dut_fv - base); end
    checks++; if (pub_digits !== 16'hAB08) begin failures++; $display("[TB] FAIL dash_digits: got %h expected ab08", pub_digits); end
    checks++; if (pub_dp !== 4'b0010) begin failures++; $display("[TB] FAIL dash_dp: got %b expected 0010", pub_dp); end
    checks++; if (pub_err !== 1'b0) begin failures++; $display("[TB] FAIL dash_err: got %b expected 0", pub_err); end
  endtask

  task automatic test_short_strobe();
    int base = dut_fv;
    logic [31:0] s = enc(16'h5678, 4'h0);
    for (int d = 3; d >= 1; d--) strobe(d, s[8*d +: 8], 20);
    strobe(0, s[7:0], STABLE - 1);
    idle(12);
    checks++; if (dut_fv !== base) begin failures++; $display("[TB] FAIL short_no_pulse: got %0d pulses expected 0", dut_fv - base); end
    strobe(0, s[7:0], 20);
    idle(5);
    checks++; if (dut_fv - base !== 1) begin failures++; $display("[TB] FAIL short_late_pulse: got %0d expected 1", dut_fv - base); end
    checks++; if (pub_digits !== 16'h5678) begin failures++; $display("[TB] FAIL short_digits: got %h expected 5678", pub_digits); end
  endtask

  task automatic test_invalid_glyph();
    logic [31:0] s = enc(16'h1034, 4'h0);
    s[23:16] = 8'b01010101;
    scan(s, 20);
    idle(5);
    checks++; if (pub_digits !== 16'h1F34) begin failures++; $display("[TB] FAIL inv_digits: got %h expected 1f34", pub_digits); end
    checks++; if (pub_err !== 1'b1) begin failures++; $display("[TB] FAIL inv_err: got %b expected 1", pub_err); end
    scan(enc(16'h9876, 4'b1001), 20);
    idle(5);
    checks++; if (pub_err !== 1'b0 || err_o !== 1'b0) begin failures++; $display("[TB] FAIL inv_clear_err: got %b expected 0", err_o); end
    checks++; if (pub_dp !== 4'b1001) begin failures++; $display("[TB] FAIL inv_clear_dp: got %b expected 1001", pub_dp); end
  endtask

  task automatic test_stale();
    int base;
    scan(enc(16'h4321, 4'h0), 20);
    rise_gap = -1;
    for (int k = 0; k < 120 && stale_o !== 1'b1; k++) idle(1);
    idle(20);
    checks++; if (rise_gap !== TIMEOUT) begin failures++; $display("[TB] FAIL stale_gap: got %0d expected %0d", rise_gap, TIMEOUT); end
    checks++; if (stale_o !== 1'b1) begin failures++; $display("[TB] FAIL stale_held: got %b expected 1", stale_o); end
    base = dut_fv;
    scan(enc(16'h2468, 4'h0), 20);
    idle(3);
    checks++; if (dut_fv - base !== 1 || pub_stale !== 1'b0) begin failures++; $display("[TB] FAIL stale_resume: got pulses=%0d stale=%b expected pulses=1 stale=0", dut_fv - base, pub_stale); end
    checks++; if (pub_digits !== 16'h2468) begin failures++; $display("[TB] FAIL stale_digits: got %h expected 2468", pub_digits); end
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [31:0] pre = enc(16'h8888, 4'hF);
    logic [31:0] post = enc(16'h1975, 4'h0);
    strobe(3, pre[31:24], 20);
    strobe(2, pre[23:16], 20);
    @(negedge clk_i); rst_ni = 1'b0; an_i = 4'hF; seg_i = 8'hFF;
    @(negedge clk_i);
    checks++; if ({digits_o, dp_o, frame_valid_o, err_o, stale_o} !== 25'd0) begin failures++; $display("[TB] FAIL midreset_outputs: got %h %b %b %b %b expected all 0", digits_o, dp_o, frame_valid_o, err_o, stale_o); end
    rst_ni = 1'b1;
    idle(4);
    base = dut_fv;
    strobe(1, post[15:8], 20);
    strobe(0, post[7:0], 20);
    strobe(3, post[31:24], 20);
    idle(5);
    checks++; if (dut_fv !== base) begin failures++; $display("[TB] FAIL midreset_early: got %0d pulses expected 0", dut_fv - base); end
    strobe(2, post[23:16], 20);
    idle(5);
    checks++; if (dut_fv - base !== 1) begin failures++; $display("[TB] FAIL midreset_pulse: got %0d expected 1", dut_fv - base); end
    checks++; if (pub_digits !== 16'h1975 || pub_dp !== 4'h0) begin failures++; $display("[TB] FAIL midreset_digits: got %h dp=%b expected 1975 dp=0000", pub_digits, pub_dp); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      for (int d = 3; d >= 0; d--) begin
        int code = $urandom_range(0, 11);
        logic [7:0] s = {GLYPH[code], 1'($urandom)};
        if ($urandom_range(0, 5) == 0) s[7:1] = 7'($urandom);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step(4'($urandom), 8'($urandom));
        strobe(d, s, $urandom_range(1, 12));
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
    end
    idle(10);
    checks++; if (dut_fv !== ref_fv) begin failures++; $display("[TB] FAIL random_pulses: got %0d expected %0d", dut_fv, ref_fv); end
  endtask

  initial begin
    rst_ni = 1'b0; an_i = 4'hF; seg_i = 8'hFF;
    test_reset();
    test_basic_scan();
    test_dash_blank();
    test_short_strobe();
    test_invalid_glyph();
    test_stale();
    test_reset_midframe();
    test_random();
    checks++; if (cyc_bad !== 0) begin failures++; $display("[TB] FAIL cycle_trace: got %0d differing cycles expected 0", cyc_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
